// File: rtl/cv32e40p_pkg.sv
// Shared types and defaults for the APU writeback queue.
package cv32e40p_pkg;

  localparam int APU_WB_QUEUE_DEPTH = 4;
  localparam int APU_WB_ADDR_WIDTH  = 6;
  localparam int APU_WB_DATA_WIDTH  = 32;

  typedef struct packed {
    logic [APU_WB_ADDR_WIDTH-1:0] waddr;
    logic [APU_WB_DATA_WIDTH-1:0] wdata;
  } apu_wb_entry_t;

endpackage

// File: rtl/cv32e40p_apu_wb_fifo.sv
// Generic in-order FIFO with per-slot valid bits and the full entry array
// exposed so the owner can search pending entries.
module cv32e40p_apu_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 38
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            head,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count,
  output logic [DEPTH-1:0][WIDTH-1:0] entries,
  output logic [DEPTH-1:0]            valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic                        do_push;
  logic                        do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];
  assign entries = mem;

  // A push into the slot freed by a same-cycle pop must leave it valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (do_pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        valid[rd_ptr] <= 1'b0;
      end
      if (do_push) begin
        wr_ptr        <= wr_ptr + 1'b1;
        valid[wr_ptr] <= 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/cv32e40p_apu_wb_queue.sv
// APU result writeback queue sharing the regfile port with LSU loads.
// Define CV32E40P_APU_WB_BYPASS_EN for the zero-latency write-through path.
module cv32e40p_apu_wb_queue
  import cv32e40p_pkg::*;
#(
  parameter int DEPTH      = APU_WB_QUEUE_DEPTH,
  parameter int ADDR_WIDTH = APU_WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APU_WB_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    apu_rvalid_i,
  input  logic                    apu_wb_en_i,
  input  logic [ADDR_WIDTH-1:0]   apu_waddr_i,
  input  logic [DATA_WIDTH-1:0]   apu_result_i,
  input  logic                    lsu_we_i,
  input  logic [3*ADDR_WIDTH-1:0] rd_addr_i,
  output logic [2:0]              rd_hit_o,
  output logic                    rf_we_o,
  output logic [ADDR_WIDTH-1:0]   rf_waddr_o,
  output logic [DATA_WIDTH-1:0]   rf_wdata_o,
  output logic                    stall_o,
  output logic                    empty_o,
  output logic                    overflow_o
);

  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
  } entry_t;

  entry_t               push_entry;
  entry_t               fifo_head;
  entry_t [DEPTH-1:0]   fifo_entries;
  logic   [DEPTH-1:0]   fifo_valid;
  logic   [CNT_W-1:0]   fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 accept;
  logic                 drain;
  logic                 bypass;
  logic                 push;

  assign accept = apu_rvalid_i & apu_wb_en_i;
  assign drain  = ~lsu_we_i & ~fifo_empty;

`ifdef CV32E40P_APU_WB_BYPASS_EN
  assign bypass = accept & fifo_empty & ~lsu_we_i;
`else
  assign bypass = 1'b0;
`endif

  assign push       = accept & ~bypass;
  assign push_entry = '{waddr: apu_waddr_i, wdata: apu_result_i};

  cv32e40p_apu_wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (drain),
    .wdata   (push_entry),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .entries (fifo_entries),
    .valid   (fifo_valid)
  );

  // The queue head always has priority over a new result so order is kept.
  always_comb begin
    rf_we_o    = drain | bypass;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (drain) begin
      rf_waddr_o = fifo_head.waddr;
      rf_wdata_o = fifo_head.wdata;
    end else if (bypass) begin
      rf_waddr_o = apu_waddr_i;
      rf_wdata_o = apu_result_i;
    end
  end

  always_comb begin
    rd_hit_o = '0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (fifo_valid[i] && (fifo_entries[i].waddr == rd_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
          rd_hit_o[k] = 1'b1;
        end
      end
    end
  end

  assign stall_o = (fifo_count >= CNT_W'(DEPTH - 1));
  assign empty_o = fifo_empty;

  // Full without a same-cycle drain means the result is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_o <= 1'b0;
    end else if (accept && fifo_full && !drain) begin
      overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cv32e40p_apu_wb_queue.sv
// Randomised and directed bench for cv32e40p_apu_wb_queue against a queue-based
// reference model; honours CV32E40P_APU_WB_BYPASS_EN like the design.
module tb_cv32e40p_apu_wb_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 6;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          apu_rvalid = 1'b0;
  logic          apu_wb_en = 1'b0;
  logic [AW-1:0] apu_waddr = '0;
  logic [DW-1:0] apu_result = '0;
  logic          lsu_we = 1'b0;
  logic [3*AW-1:0] rd_addr = '0;
  logic [2:0]    rd_hit;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          stall;
  logic          empty;
  logic          overflow;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          model_q[$];
  bit            model_ovf = 1'b0;
  logic [DW-1:0] rf_shadow [64];
  int            n_checks = 0;
  int            n_fails = 0;

  always #5 clk = ~clk;

  cv32e40p_apu_wb_queue #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .apu_rvalid_i (apu_rvalid),
    .apu_wb_en_i  (apu_wb_en),
    .apu_waddr_i  (apu_waddr),
    .apu_result_i (apu_result),
    .lsu_we_i     (lsu_we),
    .rd_addr_i    (rd_addr),
    .rd_hit_o     (rd_hit),
    .rf_we_o      (rf_we),
    .rf_waddr_o   (rf_waddr),
    .rf_wdata_o   (rf_wdata),
    .stall_o      (stall),
    .empty_o      (empty),
    .overflow_o   (overflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_bypass();
    bit byp = 1'b0;
`ifdef CV32E40P_APU_WB_BYPASS_EN
    byp = apu_rvalid && apu_wb_en && (model_q.size() == 0) && !lsu_we;
`endif
    return byp;
  endfunction

  // Compares every DUT output against what the model says this cycle.
  task automatic checkOutput();
    bit            drn = !lsu_we && (model_q.size() > 0);
    bit            byp = model_bypass();
    logic [2:0]    hit = '0;
    logic [AW-1:0] ea = '0;
    logic [DW-1:0] ed = '0;
    foreach (model_q[i])
      for (int k = 0; k < 3; k++)
        if (model_q[i].a == rd_addr[k*AW +: AW]) hit[k] = 1'b1;
    if (drn) begin
      ea = model_q[0].a;
      ed = model_q[0].d;
    end else if (byp) begin
      ea = apu_waddr;
      ed = apu_result;
    end
    check("rf_we", rf_we, drn || byp);
    if (drn || byp) begin
      check("rf_waddr", rf_waddr, ea);
      check("rf_wdata", rf_wdata, ed);
    end else begin
      check("rf_waddr_idle", rf_waddr, 0);
      check("rf_wdata_idle", rf_wdata, 0);
    end
    check("stall", stall, model_q.size() >= DEPTH - 1);
    check("empty", empty, model_q.size() == 0);
    check("overflow", overflow, model_ovf);
    check("rd_hit", rd_hit, hit);
  endtask

  task automatic update_model();
    int sz  = model_q.size();
    bit acc = apu_rvalid && apu_wb_en;
    bit drn = !lsu_we && (sz > 0);
    bit byp = model_bypass();
    if (drn) void'(model_q.pop_front());
    if (acc && !byp) begin
      if (sz < DEPTH || drn) model_q.push_back('{a: apu_waddr, d: apu_result});
      else model_ovf = 1'b1;
    end
  endtask

  task automatic applyStimulus(input bit rv, input bit wb, input logic [AW-1:0] wa,
                               input logic [DW-1:0] res, input bit lsu,
                               input logic [3*AW-1:0] rda);
    @(negedge clk);
    apu_rvalid = rv;
    apu_wb_en  = wb;
    apu_waddr  = wa;
    apu_result = res;
    lsu_we     = lsu;
    rd_addr    = rda;
    #1;
    checkOutput();
    if (rf_we) rf_shadow[rf_waddr] = rf_wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    update_model();
  endtask

  task automatic check_reset_values();
    check("rst_rf_we", rf_we, 0);
    check("rst_rf_waddr", rf_waddr, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_stall", stall, 0);
    check("rst_empty", empty, 1);
    check("rst_overflow", overflow, 0);
    check("rst_rd_hit", rd_hit, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    apu_rvalid = 1'b0;
    apu_wb_en  = 1'b0;
    lsu_we     = 1'b0;
    rst_n      = 1'b0;
    #1;
    check_reset_values();
    model_q.delete();
    model_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] ra;
    foreach (rf_shadow[i]) rf_shadow[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;

    // Single result on an idle port.
    applyStimulus(1, 1, 6'd5, 32'hDEAD_BEEF, 0, '0);
`ifdef CV32E40P_APU_WB_BYPASS_EN
    check("byp_we", rf_we, 1);
    check("byp_waddr", rf_waddr, 5);
    check("byp_wdata", rf_wdata, 32'hDEAD_BEEF);
    check("byp_empty", empty, 1);
    tick();
    applyStimulus(0, 0, '0, '0, 0, '0);
    check("byp_empty_after", empty, 1);
    check("byp_no_repeat", rf_we, 0);
    tick();
`else
    check("nobyp_we_now", rf_we, 0);
    tick();
    applyStimulus(0, 0, '0, '0, 0, '0);
    check("nobyp_we_late", rf_we, 1);
    check("nobyp_waddr", rf_waddr, 5);
    check("nobyp_wdata", rf_wdata, 32'hDEAD_BEEF);
    tick();
`endif

    // LSU holds the port while three results arrive.
    applyStimulus(1, 1, 6'd3, 32'h111, 1, '0); check("lsu_hold0", rf_we, 0); tick();
    applyStimulus(1, 1, 6'd4, 32'h222, 1, '0); check("lsu_hold1", rf_we, 0); tick();
    applyStimulus(1, 1, 6'd3, 32'h333, 1, '0); check("lsu_hold2", rf_we, 0); tick();
    applyStimulus(0, 0, '0, '0, 0, '0); check("order0_addr", rf_waddr, 3); check("order0_data", rf_wdata, 32'h111); tick();
    applyStimulus(0, 0, '0, '0, 0, '0); check("order1_addr", rf_waddr, 4); check("order1_data", rf_wdata, 32'h222); tick();
    applyStimulus(0, 0, '0, '0, 0, '0); check("order2_addr", rf_waddr, 3); check("order2_data", rf_wdata, 32'h333); tick();
    check("last_writer_wins", rf_shadow[3], 32'h333);

    // Fill, simultaneous push/pop at full, then overflow.
    applyStimulus(1, 1, 6'd10, 32'hA0, 1, '0); tick();
    applyStimulus(1, 1, 6'd11, 32'hA1, 1, '0); tick();
    applyStimulus(1, 1, 6'd12, 32'hA2, 1, '0); tick();
    applyStimulus(0, 0, '0, '0, 1, '0); check("stall_at3", stall, 1); tick();
    applyStimulus(1, 1, 6'd13, 32'hA3, 1, '0); tick();
    applyStimulus(1, 1, 6'd20, 32'h20, 0, '0);
    check("full_swap_we", rf_we, 1);
    check("full_swap_addr", rf_waddr, 10);
    tick();
    applyStimulus(0, 0, '0, '0, 1, {6'd2, 6'd11, 6'd13});
    check("full_stall", stall, 1);
    check("full_no_ovf", overflow, 0);
    check("full_hits", rd_hit, 3'b011);
    tick();
    applyStimulus(1, 1, 6'd21, 32'h21, 1, '0); tick();
    applyStimulus(0, 0, '0, '0, 1, {6'd12, 6'd20, 6'd21});
    check("ovf_set", overflow, 1);
    check("ovf_unchanged", rd_hit, 3'b110);
    tick();
    applyStimulus(0, 0, '0, '0, 0, '0); tick();
    applyStimulus(0, 0, '0, '0, 0, '0); tick();
    do_reset();
    applyStimulus(0, 0, '0, '0, 0, '0); check("post_rst_no_we", rf_we, 0); tick();

    // Hazard lookup on a queued destination.
    applyStimulus(1, 1, 6'd7, 32'h77, 1, '0); tick();
    applyStimulus(0, 0, '0, '0, 1, {6'd7, 6'd2, 6'd7}); check("hit_101", rd_hit, 3'b101); tick();
    applyStimulus(0, 0, '0, '0, 0, {6'd7, 6'd2, 6'd7}); tick();
    applyStimulus(0, 0, '0, '0, 0, {6'd7, 6'd2, 6'd7}); check("hit_cleared", rd_hit, 3'b000); tick();

    // Random traffic with a reset in the middle.
    for (int i = 0; i < 1500; i++) begin
      if (i == 750) do_reset();
      ra = AW'($urandom_range(0, 7));
      applyStimulus($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 8,
                    AW'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 9) < 4,
                    {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), ra});
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/cv32e40p_apu_wb_queue.md
# cv32e40p_apu_wb_queue

Writeback queue between the APU response channel and the register-file write port shared with LSU loads. It accepts each APU result the moment it returns and writes it through immediately when the port is free. If the port is busy, the result is held in a small in-order FIFO instead of stalling the EX stage. It also reports pending destination registers to ID for RAW hazard detection, and raises a stall when the FIFO nears capacity.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- ADDR_WIDTH, 6: register address width (GPR + FPR space).
- DATA_WIDTH, 32: result width.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- apu_rvalid_i  in  1  APU result valid this cycle.
- apu_wb_en_i  in  1  result needs a regfile write; 0 = discard (stores, LOAD-FP).
- apu_waddr_i  in  ADDR_WIDTH  destination of the result.
- apu_result_i  in  DATA_WIDTH  result data.
- lsu_we_i  in  1  LSU load occupies the write port this cycle; has priority.
- rd_addr_i  in  3×ADDR_WIDTH  ID operand addresses for hazard lookup.
- rd_hit_o  out  3  rd_addr_i[k] matches a valid queued entry.
- rf_we_o  out  1  write enable to the regfile port.
- rf_waddr_o  out  ADDR_WIDTH  write address.
- rf_wdata_o  out  DATA_WIDTH  write data.
- stall_o  out  1  stop issuing APU ops; count ≥ DEPTH-1.
- empty_o  out  1  queue empty.
- overflow_o  out  1  sticky error: an accept was attempted while full with no drain.

## Operation
- Accept = apu_rvalid_i & apu_wb_en_i. A result with apu_wb_en_i=0 is dropped: no write, no enqueue.
- Drain = ~lsu_we_i & ~empty. The head entry drives rf_* and is popped that cycle.
- Bypass: when accepting with the queue empty and lsu_we_i=0, drive rf_* directly from the apu inputs and do not enqueue.
- Otherwise an accepted result is pushed at the tail.
- Push and pop may occur in the same cycle, including when full. The count is unchanged and the accept succeeds.
- Write order strictly follows arrival. Two entries with the same waddr drain in order, so the last writer wins.
- rf_we_o=0 whenever lsu_we_i=1. The LSU drives the port externally.
- rd_hit_o[k] = OR over valid entries of (entry.waddr == rd_addr_i[k]). The bypass path is not included.
- Overflow: accept while full with no pop drops the result, sets overflow_o until reset, and leaves the queue unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.

## Timing
- Reset: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, stall_o=0, empty_o=1, overflow_o=0, rd_hit_o=0. Pointers, count and valid bits are cleared.
- Reset mid-operation discards every queued entry; no write is issued.
- Bypass latency: 0 cycles (combinational apu_* → rf_*).
- Queued latency: at least 1 cycle after the accept edge, plus one cycle for each cycle lsu_we_i is high and each older entry ahead of it.
- stall_o, empty_o and rd_hit_o come from registered state only. rd_hit_o does not depend on the current-cycle apu inputs.
- The DEPTH-1 stall threshold leaves one slot for a result already in flight when stall_o rises.

## Configuration
- CV32E40P_APU_WB_BYPASS_EN defined: zero-latency bypass as described.
- CV32E40P_APU_WB_BYPASS_EN undefined: every accepted result is enqueued, so the minimum write latency is 1 cycle. rd_hit_o then covers every pending result.

## Structure
- cv32e40p_pkg gets typedef apu_wb_entry_t {waddr, wdata} and the constant APU_WB_QUEUE_DEPTH, the default DEPTH.
- Sub-module cv32e40p_apu_wb_fifo: generic FIFO (push, pop, full, empty, count, entry array exposed for lookup).
- The top level holds the bypass mux, hazard compare, stall and overflow logic.

## Test plan
- Idle port, accept waddr=5 data=0xDEAD_BEEF → same-cycle rf_we_o=1, waddr=5, wdata=0xDEADBEEF; empty_o stays 1. Without the macro the write comes 1 cycle later.
- lsu_we_i=1 for 3 cycles while results to regs 3, 4, 3 arrive → no writes during those cycles. After lsu_we_i drops: writes 3, 4, 3 in order on consecutive cycles; the final value of reg 3 is the third result.
- Fill to 3 entries → stall_o=1. Fourth accept → full and no overflow. Fifth accept with lsu_we_i=1 → overflow_o=1, contents unchanged.
- Full queue, lsu_we_i=0, accept in the same cycle → head written, new entry queued, count stays 4, overflow_o=0.
- Queue holding reg 7, rd_addr_i={7, 2, 7} → rd_hit_o=3'b101. After reg 7 drains → rd_hit_o=0.
- Assert rst_n=0 with 2 entries queued → all outputs at reset values; no writes after release.
